i2s_rx_sample_packer: RTL and testbench

- Downstream of the I2S slave receiver, in the I2S bit-clock domain.
- Consumes its 16-bit left/right samples and push strobes.
- Pairs left and right samples into one 32-bit stereo word. In mono mode it pairs two consecutive left samples instead.
- Buffers the words in a small show-ahead FIFO. The CDC/DMA bridge pops the FIFO in the same clock domain.

---
 rtl/i2s_rx_sample_packer.sv | 149 ++++++++++++++
 tb/tb_i2s_rx_sample_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sample_packer.sv
// I2S receive sample packer: pairs 16-bit left/right samples (or two consecutive
// left samples in mono mode) into 32-bit words and buffers them in a show-ahead
// FIFO popped by the downstream bridge in the same bit-clock domain.
module i2s_rx_sample_packer #(
  parameter int unsigned AW = 3
) (
  input  logic          i2s_clk_int,
  input  logic          rst,
  input  logic          mono_en_i,
  input  logic [15:0]   data_left_i,
  input  logic [15:0]   data_right_i,
  input  logic          push_left_i,
  input  logic          push_right_i,
  input  logic          rd_en_i,
  output logic [31:0]   rd_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          pair_err_o,
  input  logic          clr_err_i
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [AW:0] LvlFull = (AW + 1)'(Depth);

  typedef enum logic {StWaitL, StWaitR} state_e;

  state_e        state_q, state_d;
  logic [15:0]   hold_q, hold_d;
  logic          mono_q;
  logic          wr_req;
  logic [31:0]   wr_word;
  logic          pair_set;
  logic          ovf_set;
  logic          wr_ok, rd_ok;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [31:0]   mem_q [Depth];
  logic          overflow_q, pair_err_q;

  // Pairing FSM: decides hold updates, completed words and sequence errors.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    wr_req   = 1'b0;
    wr_word  = '0;
    pair_set = 1'b0;
    if (mono_en_i != mono_q) begin
      // Mode change: drop any partial pair and ignore this cycle's pushes.
      state_d = StWaitL;
    end else if (mono_q) begin
      if (push_left_i) begin
        unique case (state_q)
          StWaitL: begin
            hold_d  = data_left_i;
            state_d = StWaitR;
          end
          StWaitR: begin
            wr_req  = 1'b1;
            wr_word = {hold_q, data_left_i};
            state_d = StWaitL;
          end
          default: state_d = StWaitL;
        endcase
      end
    end else begin
      if (push_left_i) begin
        // Left always (re)loads the hold; a pending left or a same-cycle right is an error.
        hold_d  = data_left_i;
        state_d = StWaitR;
        if (state_q == StWaitR || push_right_i) pair_set = 1'b1;
      end else if (push_right_i) begin
        if (state_q == StWaitR) begin
          wr_req  = 1'b1;
          wr_word = {hold_q, data_right_i};
          state_d = StWaitL;
        end else begin
          pair_set = 1'b1;
        end
      end
    end
  end

  // FSM, hold and mode registers.
  always_ff @(posedge i2s_clk_int or posedge rst) begin
    if (rst) begin
      state_q <= StWaitL;
      hold_q  <= '0;
      mono_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mono_q  <= mono_en_i;
    end
  end

  // FIFO handshake: a full FIFO still accepts a write when a pop frees the head slot.
  always_comb begin
    full_o  = (level_q == LvlFull);
    empty_o = (level_q == '0);
    rd_ok   = rd_en_i & ~empty_o;
    wr_ok   = wr_req & (~full_o | rd_en_i);
    ovf_set = wr_req & full_o & ~rd_en_i;
    level_d = level_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage, pointers and level counter.
  always_ff @(posedge i2s_clk_int or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_word;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Sticky error flags; a new set wins over a same-cycle clear.
  always_ff @(posedge i2s_clk_int or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      pair_err_q <= 1'b0;
    end else begin
      overflow_q <= ovf_set | (overflow_q & ~clr_err_i);
      pair_err_q <= pair_set | (pair_err_q & ~clr_err_i);
    end
  end

  // Output mapping; read data is show-ahead from registered storage.
  always_comb begin
    rd_data_o  = mem_q[rd_ptr_q];
    level_o    = level_q;
    overflow_o = overflow_q;
    pair_err_o = pair_err_q;
  end

endmodule

// File: tb/tb_i2s_rx_sample_packer.sv
// Self-checking bench for i2s_rx_sample_packer: directed vector table, hand-written
// boundary sequences and a randomized run against a queue-based reference model.
module tb_i2s_rx_sample_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mono_en;
  logic [15:0] dl, dr;
  logic        pl, pr, rd_en, clr;
  logic [31:0] rd_data;
  logic        empty, full, overflow, pair_err;
  logic [3:0]  level;

  int errors = 0;
  int checks = 0;

  i2s_rx_sample_packer #(.AW(3)) dut (
    .i2s_clk_int (clk),
    .rst         (rst),
    .mono_en_i   (mono_en),
    .data_left_i (dl),
    .data_right_i(dr),
    .push_left_i (pl),
    .push_right_i(pr),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .empty_o     (empty),
    .full_o      (full),
    .level_o     (level),
    .overflow_o  (overflow),
    .pair_err_o  (pair_err),
    .clr_err_i   (clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mono, pl, pr, rd, clr;
    logic [15:0] dl, dr;
    logic [3:0]  lvl;
    logic        perr;
    logic        chk_data;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic mono, logic p_l, logic p_r, logic r, logic c,
                              logic [15:0] l, logic [15:0] rr, logic [3:0] lv,
                              logic pe, logic cd, logic [31:0] d);
    vec_t v;
    v.mono = mono; v.pl = p_l; v.pr = p_r; v.rd = r; v.clr = c;
    v.dl = l; v.dr = rr; v.lvl = lv; v.perr = pe; v.chk_data = cd; v.data = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic p_l, input logic p_r, input logic [15:0] l,
                       input logic [15:0] r, input logic rd, input logic c);
    @(negedge clk);
    pl = p_l; pr = p_r; dl = l; dr = r; rd_en = rd; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mono_en = 1'b0; pl = 0; pr = 0; rd_en = 0; clr = 0; dl = 0; dr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r, input logic rd);
    cycle(1'b1, 1'b0, l, 16'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0, r, rd, 1'b0);
  endtask

  // Reference model state.
  logic [31:0] mq[$];
  logic        m_mono, m_have, m_perr, m_ovf;
  logic [15:0] m_hold;

  initial begin
    rst = 1'b1; mono_en = 0; pl = 0; pr = 0; rd_en = 0; clr = 0; dl = 0; dr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_flags", {30'd0, overflow, pair_err}, 32'd0);
    chk("rst_data", rd_data, 32'd0);

    //          mono pl pr rd clr dl        dr       lvl perr cd data
    vecs[0]  = mk(0, 1, 0, 0, 0, 16'h1234, 16'h0,    0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[3]  = mk(0, 0, 1, 0, 0, 16'h0,    16'hABCD, 1, 0, 1, 32'h1234ABCD);
    vecs[4]  = mk(0, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[5]  = mk(0, 0, 1, 0, 0, 16'h0,    16'h0001, 0, 1, 0, 32'h0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 16'h1111, 16'h0,    0, 1, 0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 16'h2222, 16'h0,    0, 1, 0, 32'h0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 16'h0,    16'h3333, 1, 1, 1, 32'h22223333);
    vecs[9]  = mk(0, 0, 0, 1, 1, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[10] = mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[11] = mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[12] = mk(1, 1, 0, 0, 0, 16'hAAAA, 16'h0,    0, 0, 0, 32'h0);
    vecs[13] = mk(1, 0, 1, 0, 0, 16'h0,    16'hFFFF, 0, 0, 0, 32'h0);
    vecs[14] = mk(1, 1, 0, 0, 0, 16'h5555, 16'h0,    1, 0, 1, 32'hAAAA5555);
    vecs[15] = mk(1, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[16] = mk(1, 1, 0, 0, 0, 16'h0BAD, 16'h0,    0, 0, 0, 32'h0);
    vecs[17] = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[18] = mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[19] = mk(1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[20] = mk(1, 1, 0, 0, 0, 16'h1357, 16'h0,    0, 0, 0, 32'h0);
    vecs[21] = mk(1, 1, 0, 0, 0, 16'h2468, 16'h0,    1, 0, 1, 32'h13572468);
    vecs[22] = mk(0, 0, 0, 1, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);
    vecs[23] = mk(0, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 0, 32'h0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      mono_en = vecs[i].mono;
      pl = vecs[i].pl; pr = vecs[i].pr; rd_en = vecs[i].rd; clr = vecs[i].clr;
      dl = vecs[i].dl; dr = vecs[i].dr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].lvl == 0));
      chk($sformatf("v%0d_perr", i), 32'(pair_err), 32'(vecs[i].perr));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'd0);
      if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), rd_data, vecs[i].data);
    end

    // Fill to full, then overflow with a ninth pair.
    do_reset();
    for (int k = 1; k <= 8; k++) push_pair(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_ovf", 32'(overflow), 32'd0);
    push_pair(16'h1009, 16'h2009, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_data", k), rd_data, {16'h1000 + 16'(k), 16'h2000 + 16'(k)});
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_level", 32'(level), 32'd0);

    // Full FIFO with simultaneous completing write and pop.
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int k = 11; k <= 18; k++) push_pair(16'h3000 + 16'(k), 16'h4000 + 16'(k), 1'b0);
    push_pair(16'h3013, 16'h4013, 1'b1);
    chk("rw_full_level", 32'(level), 32'd8);
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    for (int k = 12; k <= 19; k++) begin
      chk($sformatf("rw_drain%0d", k), rd_data, {16'h3000 + 16'(k), 16'h4000 + 16'(k)});
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    end
    chk("rw_drain_empty", 32'(empty), 32'd1);

    // Async reset mid-operation with level 5, a pending left and a set flag.
    cycle(1'b0, 1'b1, 16'h0, 16'h7777, 1'b0, 1'b0);
    chk("pre_rst_perr", 32'(pair_err), 32'd1);
    for (int k = 1; k <= 5; k++) push_pair(16'h5000 + 16'(k), 16'h6000 + 16'(k), 1'b0);
    cycle(1'b1, 1'b0, 16'h5555, 16'h0, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    @(negedge clk);
    pl = 0; pr = 0; rd_en = 0; clr = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_flags", {30'd0, overflow, pair_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 1'b1, 16'h0, 16'h8888, 1'b0, 1'b0);
    chk("post_rst_perr", 32'(pair_err), 32'd1);
    chk("post_rst_level", 32'(level), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    mq.delete();
    m_mono = 0; m_have = 0; m_perr = 0; m_ovf = 0; m_hold = 0;
    for (int n = 0; n < 600; n++) begin
      logic        r_mono, r_pl, r_pr, r_rd, r_clr;
      logic [15:0] r_dl, r_dr;
      logic        word_v, perr_set, ovf_set, popped;
      logic [31:0] word;
      r_mono = ($urandom_range(0, 31) == 0) ? ~mono_en : mono_en;
      r_pl   = ($urandom_range(0, 2) == 0);
      r_pr   = ($urandom_range(0, 2) == 0);
      r_rd   = (n < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      r_clr  = ($urandom_range(0, 15) == 0);
      r_dl   = 16'($urandom);
      r_dr   = 16'($urandom);

      word_v = 0; word = 0; perr_set = 0; ovf_set = 0;
      if (r_mono != m_mono) begin
        m_mono = r_mono;
        m_have = 0;
      end else if (m_mono) begin
        if (r_pl) begin
          if (m_have) begin word_v = 1; word = {m_hold, r_dl}; m_have = 0; end
          else begin m_hold = r_dl; m_have = 1; end
        end
      end else if (r_pl) begin
        if (m_have || r_pr) perr_set = 1;
        m_hold = r_dl;
        m_have = 1;
      end else if (r_pr) begin
        if (m_have) begin word_v = 1; word = {m_hold, r_dr}; m_have = 0; end
        else perr_set = 1;
      end
      popped = r_rd && mq.size() > 0;
      if (word_v && mq.size() == 8 && !r_rd) ovf_set = 1;
      if (popped) void'(mq.pop_front());
      if (word_v && !ovf_set) mq.push_back(word);
      m_perr = perr_set | (m_perr & ~r_clr);
      m_ovf  = ovf_set | (m_ovf & ~r_clr);

      @(negedge clk);
      mono_en = r_mono; pl = r_pl; pr = r_pr; rd_en = r_rd; clr = r_clr; dl = r_dl; dr = r_dr;
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_level", n), 32'(level), 32'(mq.size()));
      chk($sformatf("rnd%0d_full", n), 32'(full), 32'(mq.size() == 8));
      chk($sformatf("rnd%0d_empty", n), 32'(empty), 32'(mq.size() == 0));
      chk($sformatf("rnd%0d_perr", n), 32'(pair_err), 32'(m_perr));
      chk($sformatf("rnd%0d_ovf", n), 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) chk($sformatf("rnd%0d_data", n), rd_data, mq[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
